counter_checker: RTL and testbench

Receiving end of a getter-style free-running counter output. Samples a wrapping WIDTH-bit count, which increments by one per valid sample from the producer, and verifies it against its own expected value. Tracks lock, counts mismatches and wrap-arounds, and latches the last bad value. Sits beside any counter-producing module as a self-checking consumer in simulation and on-chip bring-up.

---
 rtl/counter_checker_if.sv | 9 +
 rtl/counter_checker.sv | 70 +++++++
 tb/tb_counter_checker.sv | 126 ++++++++++++
 3 files changed

// File: rtl/counter_checker_if.sv
// counter_checker_if: sample bus from a free-running counter producer to its checker.
interface counter_checker_if #(
   parameter int WIDTH = 7
);
   logic             sample_valid;
   logic [WIDTH-1:0] count_in;
   modport master (output sample_valid, count_in);
   modport slave  (input  sample_valid, count_in);
endinterface

// File: rtl/counter_checker.sv
// counter_checker: locks onto a wrapping counter stream and tracks mismatches, wraps and the last bad value.
module counter_checker #(
   parameter int WIDTH     = 7,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clock,
   input  logic                 rst_n,
   counter_checker_if.slave     bus,
   input  logic                 clear,
   output logic [1:0]           get_state_ret,
   output logic                 get_locked_ret,
   output logic [WIDTH-1:0]     get_expected_ret,
   output logic [CNT_WIDTH-1:0] get_errors_ret,
   output logic [CNT_WIDTH-1:0] get_wraps_ret,
   output logic [WIDTH-1:0]     get_last_bad_ret
);
   typedef enum logic [1:0] {SEEK, TRACK, FAULT, ILLEGAL} state_t;
   state_t               state;
   logic                 locked;
   logic [WIDTH-1:0]     expected;
   logic [CNT_WIDTH-1:0] errors;
   logic [CNT_WIDTH-1:0] wraps;
   logic [WIDTH-1:0]     last_bad;
   always_ff @(posedge clock or negedge rst_n)
      if (!rst_n) begin
         state    <= SEEK;
         locked   <= 1'b0;
         expected <= '0;
         errors   <= '0;
         wraps    <= '0;
         last_bad <= '0;
      end else begin
         case (state)
            SEEK, FAULT:
               if (bus.sample_valid) begin
                  expected <= bus.count_in + 1'b1;
                  state    <= TRACK;
                  locked   <= 1'b1;
               end
            TRACK:
               if (bus.sample_valid) begin
                  if (bus.count_in == expected) begin
                     expected <= expected + 1'b1;
                     if (&bus.count_in && !(&wraps)) wraps <= wraps + 1'b1;
                  end else begin
                     if (!(&errors)) errors <= errors + 1'b1;
                     last_bad <= bus.count_in;
                     state    <= FAULT;
                     locked   <= 1'b0;
                  end
               end
            default: begin
               state  <= SEEK;
               locked <= 1'b0;
            end
         endcase
         // clear overrides the statistics only; the FSM and expected still move
         if (clear) begin
            errors   <= '0;
            wraps    <= '0;
            last_bad <= '0;
         end
      end
   assign get_state_ret    = state;
   assign get_locked_ret   = locked;
   assign get_expected_ret = expected;
   assign get_errors_ret   = errors;
   assign get_wraps_ret    = wraps;
   assign get_last_bad_ret = last_bad;
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: directed checks of seeding, wrap counting, mismatch/resync, gaps, saturation, clear and illegal-state recovery.
module tb_counter_checker;
   logic       clock = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic [1:0] state;
   logic       locked;
   logic [6:0] expected, last_bad;
   logic [7:0] errors, wraps;
   int         total = 0;
   int         passed = 0;
   int         fails = 0;
   counter_checker_if #(.WIDTH(7)) bus ();
   counter_checker #(.WIDTH(7), .CNT_WIDTH(8)) dut (
      .clock            (clock),
      .rst_n            (rst_n),
      .bus              (bus),
      .clear            (clear),
      .get_state_ret    (state),
      .get_locked_ret   (locked),
      .get_expected_ret (expected),
      .get_errors_ret   (errors),
      .get_wraps_ret    (wraps),
      .get_last_bad_ret (last_bad)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask
   task automatic chk_all(input string tag, input logic [1:0] st, input logic lk, input logic [6:0] ex,
                          input logic [7:0] er, input logic [7:0] wr, input logic [6:0] lb);
      chk({tag, ".state"}, 32'(state), 32'(st));
      chk({tag, ".locked"}, 32'(locked), 32'(lk));
      chk({tag, ".expected"}, 32'(expected), 32'(ex));
      chk({tag, ".errors"}, 32'(errors), 32'(er));
      chk({tag, ".wraps"}, 32'(wraps), 32'(wr));
      chk({tag, ".last_bad"}, 32'(last_bad), 32'(lb));
   endtask
   // drive one cycle of inputs, then sample 1 time unit after the edge
   task automatic cyc(input logic v, input logic [6:0] c, input logic clr);
      bus.sample_valid = v;
      bus.count_in     = c;
      clear            = clr;
      @(posedge clock);
      #1;
   endtask
   initial begin
      bus.sample_valid = 1'b0;
      bus.count_in     = '0;
      @(posedge clock);
      #1;
      chk_all("reset", 2'd0, 1'b0, 7'h00, 8'h00, 8'h00, 7'h00);
      rst_n = 1'b1;
      cyc(1, 7'h05, 0);
      chk_all("seed05", 2'd1, 1'b1, 7'h06, 8'h00, 8'h00, 7'h00);
      cyc(1, 7'h06, 0);
      cyc(1, 7'h07, 0);
      chk_all("track07", 2'd1, 1'b1, 7'h08, 8'h00, 8'h00, 7'h00);
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 2'd0, 1'b0, 7'h00, 8'h00, 8'h00, 7'h00);
      cyc(1, 7'h44, 0);
      chk_all("rst_held", 2'd0, 1'b0, 7'h00, 8'h00, 8'h00, 7'h00);
      rst_n = 1'b1;
      cyc(1, 7'h05, 0);
      chk_all("reseed05", 2'd1, 1'b1, 7'h06, 8'h00, 8'h00, 7'h00);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      cyc(1, 7'h7D, 0);
      chk_all("seed7d", 2'd1, 1'b1, 7'h7E, 8'h00, 8'h00, 7'h00);
      cyc(1, 7'h7E, 0);
      chk("wrap7e.locked", 32'(locked), 32'd1);
      cyc(1, 7'h7F, 0);
      chk_all("wrap7f", 2'd1, 1'b1, 7'h00, 8'h00, 8'h01, 7'h00);
      cyc(1, 7'h00, 0);
      chk("wrap00.locked", 32'(locked), 32'd1);
      cyc(1, 7'h01, 0);
      chk_all("wrap01", 2'd1, 1'b1, 7'h02, 8'h00, 8'h01, 7'h00);
      for (int i = 2; i < 16; i++) cyc(1, 7'(i), 0);
      chk_all("run_to_10", 2'd1, 1'b1, 7'h10, 8'h00, 8'h01, 7'h00);
      cyc(1, 7'h13, 0);
      chk_all("mis13", 2'd2, 1'b0, 7'h10, 8'h01, 8'h01, 7'h13);
      cyc(1, 7'h20, 0);
      chk_all("resync20", 2'd1, 1'b1, 7'h21, 8'h01, 8'h01, 7'h13);
      cyc(1, 7'h21, 0);
      chk_all("track21", 2'd1, 1'b1, 7'h22, 8'h01, 8'h01, 7'h13);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 7'($urandom), 0);
         chk_all("gap", 2'd1, 1'b1, 7'h22, 8'h01, 8'h01, 7'h13);
      end
      for (int i = 0; i < 300; i++) begin
         cyc(1, 7'h40, 0);
         cyc(1, 7'h50, 0);
      end
      chk_all("sat", 2'd1, 1'b1, 7'h51, 8'hFF, 8'h01, 7'h40);
      cyc(1, 7'h41, 0);
      chk_all("sat_hold", 2'd2, 1'b0, 7'h51, 8'hFF, 8'h01, 7'h41);
      cyc(1, 7'h50, 0);
      cyc(1, 7'h40, 1);
      chk_all("clr_mis", 2'd2, 1'b0, 7'h51, 8'h00, 8'h00, 7'h00);
      cyc(1, 7'h7E, 0);
      cyc(1, 7'h7F, 0);
      chk_all("wrap_again", 2'd1, 1'b1, 7'h00, 8'h00, 8'h01, 7'h00);
      cyc(1, 7'h10, 0);
      cyc(1, 7'h7E, 0);
      chk_all("pre_clr_wrap", 2'd1, 1'b1, 7'h7F, 8'h01, 8'h01, 7'h10);
      cyc(1, 7'h7F, 1);
      chk_all("clr_wrap", 2'd1, 1'b1, 7'h00, 8'h00, 8'h00, 7'h00);
      force dut.state = dut.state.last();
      cyc(0, 7'h00, 0);
      release dut.state;
      cyc(0, 7'h00, 0);
      chk("illegal.state", 32'(state), 32'd0);
      chk("illegal.locked", 32'(locked), 32'd0);
      cyc(1, 7'h33, 0);
      chk_all("post_illegal", 2'd1, 1'b1, 7'h34, 8'h00, 8'h00, 7'h00);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
